// File: rtl/fifo_ms_read_sched.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_ms_read_sched
//  Description : Read-side scheduler for the multi-stream tagged FIFO.
//                Weighted round-robin over per-stream queues (up to BURST
//                consecutive pops per stream), one-hot pop vector, registered
//                valid/ready output stage and sticky tag-mismatch detection.
//  Revision    : 1.0  initial release
// ============================================================================
module fifo_ms_read_sched #(
    parameter  int DATA_WIDTH = 8,
    parameter  int FLUX       = 2,
    parameter  int BURST      = 2,
    localparam int TAG_WIDTH  = (FLUX > 1) ? $clog2(FLUX) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            enable,
    input  logic [FLUX-1:0]                 stream_mask,
    input  logic [FLUX-1:0]                 fifo_empty,
    input  logic [DATA_WIDTH+TAG_WIDTH-1:0] fifo_dout,
    output logic [FLUX-1:0]                 fifo_read,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic [DATA_WIDTH-1:0]           m_data,
    output logic [TAG_WIDTH-1:0]            m_tag,
    output logic                            tag_err,
    output logic                            busy
);

    localparam int CNT_WIDTH = $clog2(BURST + 1);

    localparam logic [CNT_WIDTH-1:0] c_burst    = CNT_WIDTH'(BURST);
    localparam logic [CNT_WIDTH-1:0] c_cnt_one  = CNT_WIDTH'(1);
    localparam logic [TAG_WIDTH-1:0] c_last_str = TAG_WIDTH'(FLUX - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SERVE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [TAG_WIDTH-1:0]  cur_q, cur_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  m_valid_q, m_valid_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic [TAG_WIDTH-1:0]  m_tag_q, m_tag_d;
    logic                  tag_err_q, tag_err_d;

    logic [FLUX-1:0]       w_elig;
    logic [2*FLUX-1:0]     w_elig2;
    logic [FLUX-1:0]       w_rot;
    int                    w_off;
    int                    w_scan;
    logic                  w_stay;
    logic [TAG_WIDTH-1:0]  w_grant;
    logic                  w_pop;

    // Grant selection: stay on cur while its burst has room, else rotate.
    // cnt==0 only after reset and means "no burst in progress", so the first
    // grant scans from cur+1 (stream 0) instead of sticking to FLUX-1.
    always_comb begin
        w_elig  = ~fifo_empty & stream_mask;
        w_elig2 = {w_elig, w_elig};
        // Eligibility rotated so bit j corresponds to stream cur+1+j.
        w_rot   = FLUX'(w_elig2 >> (int'(cur_q) + 1));
        w_off   = 0;
        for (int j = FLUX - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_off = j;
            end
        end
        w_scan = int'(cur_q) + 1 + w_off;
        if (w_scan >= FLUX) begin
            w_scan = w_scan - FLUX;
        end
        w_stay  = w_elig[cur_q] && (cnt_q != '0) && (cnt_q < c_burst);
        w_grant = w_stay ? cur_q : TAG_WIDTH'(w_scan);
        w_pop   = enable && (!m_valid_q || m_ready) && (|w_elig);
    end

    // Datapath next state: load on pop, otherwise drop the word on accept.
    always_comb begin
        cur_d     = cur_q;
        cnt_d     = cnt_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_tag_d   = m_tag_q;
        tag_err_d = tag_err_q;
        if (w_pop) begin
            m_valid_d = 1'b1;
            m_data_d  = fifo_dout[DATA_WIDTH-1:0];
            m_tag_d   = w_grant;
            cur_d     = w_grant;
            // Regrant after an exhausted burst (cur is the only candidate)
            // restarts the count instead of overrunning BURST.
            cnt_d     = w_stay ? (cnt_q + c_cnt_one) : c_cnt_one;
            if (fifo_dout[DATA_WIDTH +: TAG_WIDTH] != w_grant) begin
                tag_err_d = 1'b1;
            end
        end else if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q     <= c_last_str;
            cnt_q     <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_tag_q   <= '0;
            tag_err_q <= 1'b0;
        end else begin
            cur_q     <= cur_d;
            cnt_q     <= cnt_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_tag_q   <= m_tag_d;
            tag_err_q <= tag_err_d;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: IDLE whenever the output empties, DRAIN while a word
    // waits with enable low, SERVE otherwise.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (w_pop) begin
                    state_d = S_SERVE;
                end
            end
            S_SERVE: begin
                if (!m_valid_d) begin
                    state_d = S_IDLE;
                end else if (!enable) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!m_valid_d) begin
                    state_d = S_IDLE;
                end else if (enable) begin
                    state_d = S_SERVE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM outputs: pop vector (held off during reset) and busy flag.
    always_comb begin
        fifo_read = '0;
        if (rst_n && w_pop) begin
            fifo_read = FLUX'(1) << w_grant;
        end
        busy = (state_q != S_IDLE);
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_tag   = m_tag_q;
    assign tag_err = tag_err_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_ms_read_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_ms_read_sched
//  Description : Self-checking bench for fifo_ms_read_sched with a two-stream
//                FIFO emulation and a behavioural scheduler model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fifo_ms_read_sched;

    localparam int NS    = 2;
    localparam int BURST = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [1:0] stream_mask;
    logic [1:0] fifo_empty;
    logic [8:0] fifo_dout;
    logic [1:0] fifo_read;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_tag;
    logic       tag_err;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    // Two-stream FIFO emulation: circular storage with free-running pointers.
    logic [7:0] mem0 [32];
    logic [7:0] mem1 [32];
    int  rd0 = 0, rd1 = 0, wr0 = 0, wr1 = 0;
    bit  corrupt = 1'b0;

    assign fifo_empty = {rd1 == wr1, rd0 == wr0};
    assign fifo_dout  = fifo_read[1] ? {~corrupt, mem1[rd1 % 32]} : {1'b0, mem0[rd0 % 32]};

    always @(posedge clk) begin
        if (fifo_read[0]) rd0 <= rd0 + 1;
        if (fifo_read[1]) rd1 <= rd1 + 1;
    end

    always #5 clk = ~clk;

    fifo_ms_read_sched #(.DATA_WIDTH(8), .FLUX(NS), .BURST(BURST)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .stream_mask(stream_mask),
        .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_read(fifo_read),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_tag(m_tag),
        .tag_err(tag_err), .busy(busy)
    );

    // Behavioural model: last served stream, length of its current run,
    // contents of the output register and the sticky error.
    int         mcur, mrun;
    bit         mvalid, mterr;
    logic [7:0] mdata;
    logic       mtag;
    int         n_cur, n_run;
    bit         n_valid, n_terr;
    logic [7:0] n_data;
    logic       n_tag;
    int         exp_grant;
    logic [1:0] exp_read;

    task automatic push(input int s, input logic [7:0] d);
        if (s == 0) begin mem0[wr0 % 32] = d; wr0++; end
        else        begin mem1[wr1 % 32] = d; wr1++; end
    endtask

    task automatic model_reset();
        mcur = NS - 1; mrun = 0; mvalid = 0; mdata = 8'h00; mtag = 1'b0; mterr = 0;
    endtask

    // Predict this cycle's pop and next register contents from the rules:
    // keep the current stream while its run is shorter than BURST, otherwise
    // take the next eligible stream after it in circular order.
    task automatic model_eval();
        bit elig [NS];
        bit can;
        int g;
        elig[0] = (rd0 != wr0) && stream_mask[0];
        elig[1] = (rd1 != wr1) && stream_mask[1];
        can = enable && (!mvalid || m_ready);
        g = -1;
        if (mrun > 0 && mrun < BURST && elig[mcur]) g = mcur;
        else
            for (int off = 1; off <= NS; off++)
                if (g < 0 && elig[(mcur + off) % NS]) g = (mcur + off) % NS;
        if (!can) g = -1;
        exp_grant = g;
        exp_read  = (g < 0) ? 2'b00 : 2'(1 << g);
        n_cur = mcur; n_run = mrun; n_valid = mvalid; n_terr = mterr;
        n_data = mdata; n_tag = mtag;
        if (g >= 0) begin
            n_valid = 1;
            n_data  = (g == 0) ? mem0[rd0 % 32] : mem1[rd1 % 32];
            n_tag   = g[0];
            n_run   = (g == mcur && mrun > 0 && mrun < BURST) ? mrun + 1 : 1;
            n_cur   = g;
            if (g == 1 && corrupt) n_terr = 1;
        end else if (mvalid && m_ready) begin
            n_valid = 0;
        end
    endtask

    task automatic model_commit();
        mcur = n_cur; mrun = n_run; mvalid = n_valid; mterr = n_terr;
        mdata = n_data; mtag = n_tag;
    endtask

    // Inputs are driven at the falling edge; outputs are sampled 1 ns later.
    task automatic cycle_start();
        #1;
        model_eval();
    endtask

    task automatic cycle_end();
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; enable = 1'b0; m_ready = 1'b0; stream_mask = 2'b00; corrupt = 1'b0;
        repeat (2) @(negedge clk);
        wr0 = rd0; wr1 = rd1;
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        enable = 1'b1; stream_mask = 2'b11; m_ready = 1'b1;
        #1;
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", m_valid); end
        checks++; if (m_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", m_data); end
        checks++; if (m_tag !== 1'b0) begin failures++; $display("FAIL reset_tag got=%b exp=0", m_tag); end
        checks++; if (tag_err !== 1'b0) begin failures++; $display("FAIL reset_tagerr got=%b exp=0", tag_err); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (fifo_read !== 2'b00) begin failures++; $display("FAIL reset_read got=%b exp=00", fifo_read); end
    endtask

    task automatic test_wrr_order();
        int got[$];
        int ord[8] = '{0, 0, 1, 1, 0, 0, 1, 1};
        bit bad;
        do_reset();
        for (int i = 0; i < 4; i++) begin push(0, 8'($urandom)); push(1, 8'($urandom)); end
        enable = 1'b1; m_ready = 1'b1; stream_mask = 2'b11;
        for (int c = 0; c < 10; c++) begin
            cycle_start();
            checks++;
            if (fifo_read !== exp_read || m_valid !== mvalid || busy !== mvalid || tag_err !== mterr ||
                (mvalid && (m_data !== mdata || m_tag !== mtag))) begin
                failures++;
                $display("FAIL wrr c=%0d read=%b/%b valid=%b/%b data=%h/%h tag=%b/%b (got/exp)",
                         c, fifo_read, exp_read, m_valid, mvalid, m_data, mdata, m_tag, mtag);
            end
            if (fifo_read == 2'b01) got.push_back(0);
            else if (fifo_read == 2'b10) got.push_back(1);
            cycle_end();
        end
        bad = (got.size() != 8);
        if (!bad) for (int i = 0; i < 8; i++) if (got[i] != ord[i]) bad = 1;
        checks++;
        if (bad) begin failures++; $display("FAIL wrr_order pops=%0d got=%p exp=%p", got.size(), got, ord); end
    endtask

    task automatic test_single_stream();
        int run;
        do_reset();
        for (int i = 0; i < 5; i++) push(1, 8'($urandom));
        enable = 1'b1; m_ready = 1'b1; stream_mask = 2'b11;
        run = 0;
        for (int c = 0; c < 8; c++) begin
            cycle_start();
            checks++;
            if (fifo_read !== exp_read || m_valid !== mvalid || busy !== mvalid ||
                (mvalid && (m_data !== mdata || m_tag !== mtag))) begin
                failures++;
                $display("FAIL single c=%0d read=%b/%b valid=%b/%b data=%h/%h (got/exp)",
                         c, fifo_read, exp_read, m_valid, mvalid, m_data, mdata);
            end
            if (c < 5 && fifo_read === 2'b10) run++;
            cycle_end();
        end
        checks++;
        if (run != 5) begin failures++; $display("FAIL single_nobubble pops=%0d exp=5", run); end
    endtask

    task automatic test_backpressure();
        logic [7:0] held;
        logic       held_tag;
        do_reset();
        for (int i = 0; i < 3; i++) begin push(0, 8'($urandom)); push(1, 8'($urandom)); end
        enable = 1'b1; stream_mask = 2'b11;
        for (int c = 0; c < 8; c++) begin
            m_ready = (c == 0 || c >= 4);
            cycle_start();
            checks++;
            if (fifo_read !== exp_read || m_valid !== mvalid || busy !== mvalid ||
                (mvalid && (m_data !== mdata || m_tag !== mtag))) begin
                failures++;
                $display("FAIL bp c=%0d read=%b/%b valid=%b/%b data=%h/%h (got/exp)",
                         c, fifo_read, exp_read, m_valid, mvalid, m_data, mdata);
            end
            if (c == 1) begin held = mdata; held_tag = mtag; end
            if (c >= 1 && c <= 3) begin
                checks++;
                if (fifo_read !== 2'b00 || m_data !== held || m_tag !== held_tag) begin
                    failures++;
                    $display("FAIL bp_hold c=%0d read=%b data=%h/%h tag=%b/%b", c, fifo_read, m_data, held, m_tag, held_tag);
                end
            end
            if (c == 4) begin
                checks++;
                if (fifo_read !== 2'b01) begin failures++; $display("FAIL bp_resume read=%b exp=01", fifo_read); end
            end
            cycle_end();
        end
    endtask

    task automatic test_drain();
        do_reset();
        push(0, 8'($urandom)); push(0, 8'($urandom));
        enable = 1'b1; m_ready = 1'b0; stream_mask = 2'b11;
        for (int c = 0; c < 5; c++) begin
            enable  = (c == 0);
            m_ready = (c >= 3);
            cycle_start();
            checks++;
            if (fifo_read !== exp_read || m_valid !== mvalid || busy !== mvalid ||
                (mvalid && (m_data !== mdata || m_tag !== mtag))) begin
                failures++;
                $display("FAIL drain c=%0d read=%b/%b valid=%b/%b busy=%b data=%h/%h (got/exp)",
                         c, fifo_read, exp_read, m_valid, mvalid, busy, m_data, mdata);
            end
            if (c == 1 || c == 2) begin
                checks++;
                if (busy !== 1'b1 || fifo_read !== 2'b00 || m_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL drain_hold c=%0d busy=%b valid=%b read=%b exp=1,1,00", c, busy, m_valid, fifo_read);
                end
            end
            if (c == 4) begin
                checks++;
                if (busy !== 1'b0 || m_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL drain_idle busy=%b valid=%b exp=0,0", busy, m_valid);
                end
            end
            cycle_end();
        end
    endtask

    task automatic test_mask_tagerr();
        do_reset();
        for (int i = 0; i < 3; i++) begin push(0, 8'($urandom)); push(1, 8'($urandom)); end
        enable = 1'b1; m_ready = 1'b1; stream_mask = 2'b10; corrupt = 1'b1;
        for (int c = 0; c < 9; c++) begin
            if (c >= 5) stream_mask = 2'b00;
            cycle_start();
            checks++;
            if (fifo_read !== exp_read || m_valid !== mvalid || tag_err !== mterr || fifo_read[0] !== 1'b0 ||
                (mvalid && (m_data !== mdata || m_tag !== mtag))) begin
                failures++;
                $display("FAIL mask c=%0d read=%b/%b valid=%b/%b err=%b/%b tag=%b/%b (got/exp)",
                         c, fifo_read, exp_read, m_valid, mvalid, tag_err, mterr, m_tag, mtag);
            end
            cycle_end();
        end
        checks++;
        if (tag_err !== 1'b1) begin failures++; $display("FAIL tagerr_sticky got=%b exp=1", tag_err); end
        do_reset();
        #1;
        checks++;
        if (tag_err !== 1'b0) begin failures++; $display("FAIL tagerr_clear got=%b exp=0", tag_err); end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 3; i++) begin push(0, 8'($urandom)); push(1, 8'($urandom)); end
        enable = 1'b1; m_ready = 1'b0; stream_mask = 2'b11;
        cycle_start();
        cycle_end();
        #1;
        checks++;
        if (m_valid !== 1'b1) begin failures++; $display("FAIL arst_pre valid=%b exp=1", m_valid); end
        rst_n = 1'b0;
        m_ready = 1'b1;
        #1;
        checks++;
        if (m_valid !== 1'b0 || fifo_read !== 2'b00 || busy !== 1'b0) begin
            failures++;
            $display("FAIL arst_immediate valid=%b read=%b busy=%b exp=0,00,0", m_valid, fifo_read, busy);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cycle_start();
            checks++;
            if (fifo_read !== exp_read || m_valid !== mvalid ||
                (mvalid && (m_data !== mdata || m_tag !== mtag))) begin
                failures++;
                $display("FAIL arst_after c=%0d read=%b/%b valid=%b/%b data=%h/%h (got/exp)",
                         c, fifo_read, exp_read, m_valid, mvalid, m_data, mdata);
            end
            if (c == 0) begin
                checks++;
                if (fifo_read !== 2'b01) begin failures++; $display("FAIL arst_first_grant read=%b exp=01", fifo_read); end
            end
            cycle_end();
        end
    endtask

    task automatic test_random();
        int s;
        do_reset();
        for (int c = 0; c < 300; c++) begin
            enable      = ($urandom_range(0, 3) != 0);
            m_ready     = ($urandom_range(0, 2) != 0);
            stream_mask = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                s = $urandom_range(0, 1);
                if ((s == 0 && wr0 - rd0 < 16) || (s == 1 && wr1 - rd1 < 16)) push(s, 8'($urandom));
            end
            cycle_start();
            checks++;
            if (fifo_read !== exp_read || m_valid !== mvalid || busy !== mvalid || tag_err !== mterr ||
                (mvalid && (m_data !== mdata || m_tag !== mtag))) begin
                failures++;
                $display("FAIL random c=%0d read=%b/%b valid=%b/%b busy=%b data=%h/%h tag=%b/%b (got/exp)",
                         c, fifo_read, exp_read, m_valid, mvalid, busy, m_data, mdata, m_tag, mtag);
            end
            cycle_end();
        end
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; m_ready = 1'b0; stream_mask = 2'b00;
        model_reset();
        test_reset();
        test_wrr_order();
        test_single_stream();
        test_backpressure();
        test_drain();
        test_mask_tagerr();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
